serial_alu_seq: RTL

SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_bit_slice.sv | 28 ++
 rtl/serial_alu_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op-code constants, FSM state encoding and op legality helper
// for the bit-serial ALU.
package alu_pkg;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] o);
    return (o == OP_AND) || (o == OP_OR) || (o == OP_ADD) ||
           (o == OP_SUB) || (o == OP_NOR);
  endfunction

  function automatic logic op_is_arith(input logic [3:0] o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction
endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: AND / OR / full-add on optionally inverted
// inputs; Operation 11 yields 0. Carryout is always the full-adder carry.
module alu_bit_slice (
  input  logic       A,
  input  logic       B,
  input  logic       Ainvert,
  input  logic       Binvert,
  input  logic       CarryIn,
  input  logic [1:0] Operation,
  output logic       Result,
  output logic       Carryout
);
  logic a_i, b_i;

  assign a_i      = A ^ Ainvert;
  assign b_i      = B ^ Binvert;
  assign Carryout = (a_i & b_i) | (a_i & CarryIn) | (b_i & CarryIn);

  always_comb begin
    Result = 1'b0;
    case (Operation)
      2'b00:   Result = a_i & b_i;
      2'b01:   Result = a_i | b_i;
      2'b10:   Result = a_i ^ b_i ^ CarryIn;
      default: Result = 1'b0;
    endcase
  end
endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU: shifts operands LSB first through one alu_bit_slice,
// publishing flags and result in DONE, WIDTH+1 edges after the accepting edge.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             op_err
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PUBLISH  = CW'(WIDTH);

  state_t         state;
  logic [WIDTH-1:0] sh_a, sh_b, sh_r;
  logic [3:0]     op_q;
  logic [CW-1:0]  cnt;
  logic           carry_q;
  logic           cin_msb;
  logic           slice_res, slice_cout;
  logic           legal, arith;

  alu_bit_slice u_slice (
    .A        (sh_a[0]),
    .B        (sh_b[0]),
    .Ainvert  (op_q[3]),
    .Binvert  (op_q[2]),
    .CarryIn  (carry_q),
    .Operation(op_q[1:0]),
    .Result   (slice_res),
    .Carryout (slice_cout)
  );

  assign legal = op_is_legal(op_q);
  assign arith = op_is_arith(op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh_a      <= '0;
      sh_b      <= '0;
      sh_r      <= '0;
      op_q      <= '0;
      cnt       <= '0;
      carry_q   <= 1'b0;
      cin_msb   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            sh_r    <= '0;
            op_q    <= op;
            cnt     <= '0;
            carry_q <= op[2];
            cin_msb <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (cnt == CNT_PUBLISH) begin
            // An illegal op still runs the full sequence but publishes clean flags.
            result    <= legal ? sh_r : '0;
            zero      <= legal ? (sh_r == '0) : 1'b1;
            carry_out <= legal ? carry_q : 1'b0;
            overflow  <= (legal && arith) ? (cin_msb ^ carry_q) : 1'b0;
            op_err    <= ~legal;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            sh_a    <= sh_a >> 1;
            sh_b    <= sh_b >> 1;
            sh_r    <= {slice_res, sh_r[WIDTH-1:1]};
            carry_q <= slice_cout;
            if (cnt == CNT_LAST_BIT) cin_msb <= carry_q;
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
